// File: rtl/revo_phase_select_trigger_encoder.sv
// ---------------------------------------------------------------------------
// revo_phase_select_trigger_encoder
//
// Back end of the revolution-marker path. Consumes 4-sample words of
// deserialized revo input and produces:
//   - per-bit rising-edge pulses,
//   - a one-time phase selection (select2/select4) for the clock-phase
//     BUFGMUX tree, captured on the first recognised edge pattern,
//   - a one-cycle trigger and its complement for the ODDR clock-encoding gate,
//   - an 8-bit serializer word (WORD_TRG for one cycle per trigger),
//   - a stretched "revo seen" LED indicator.
//
// Ports:
//   clock         in   word clock, all logic on rising edge
//   reset         in   synchronous, active-high
//   revo_stream   in   [3:0] deserialized revo samples (already in clock domain)
//   pulse_stream  out  [3:0] registered rising-edge pulses per sample bit
//   phase_locked  out  high once a phase has been captured
//   select2       out  [1:0] phase select (0/90/180/270 degrees)
//   select4       out  [3:0] edge pattern captured at lock
//   long_trg      out  registered OR of revo_stream
//   short_trg     out  one-cycle pulse on each rising edge of long_trg
//   trg           out  registered copy of short_trg
//   trg_inv       out  complement of trg (ODDR CE)
//   word          out  [7:0] serializer word
//   led_revo      out  stretched activity indicator
// ---------------------------------------------------------------------------
module revo_phase_select_trigger_encoder #(
   parameter int         STRETCH_LOG2 = 19,
   parameter logic [7:0] WORD_TRG     = 8'b11001100,
   parameter logic [7:0] WORD_NULL    = 8'b00000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] revo_stream,
   output logic [3:0] pulse_stream,
   output logic       phase_locked,
   output logic [1:0] select2,
   output logic [3:0] select4,
   output logic       long_trg,
   output logic       short_trg,
   output logic       trg,
   output logic       trg_inv,
   output logic [7:0] word,
   output logic       led_revo
);

   localparam logic [STRETCH_LOG2-1:0] CNT_ONE = {{(STRETCH_LOG2-1){1'b0}}, 1'b1};

   logic [3:0]              r_stream_d;
   logic                    r_long_trg_d;
   logic                    r_sticky;
   logic [STRETCH_LOG2-1:0] r_counter;

   logic                    w_lock_hit;
   logic [1:0]              w_lock_sel;
   logic                    w_any_pulse;
   logic                    w_wrap;

   // ------------------------------------------------------------------------
   // Edge detect: a pulse marks a sample bit that went 0 -> 1 since the
   // previous word.
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_stream_d   <= 4'b0000;
         pulse_stream <= 4'b0000;
      end else begin
         r_stream_d   <= revo_stream;
         pulse_stream <= revo_stream & ~r_stream_d;
      end
   end

   // ------------------------------------------------------------------------
   // Phase lock. Only contiguous edge patterns anchored at the MSB identify
   // where within the word the marker edge fell; everything else (including
   // isolated LSB or non-contiguous pulses) is treated as noise.
   // ------------------------------------------------------------------------
   always_comb begin
      w_lock_hit = 1'b0;
      w_lock_sel = 2'b00;
      case (pulse_stream)
         4'b1111: begin w_lock_hit = 1'b1; w_lock_sel = 2'b00; end
         4'b1110: begin w_lock_hit = 1'b1; w_lock_sel = 2'b01; end
         4'b1100: begin w_lock_hit = 1'b1; w_lock_sel = 2'b10; end
         4'b1000: begin w_lock_hit = 1'b1; w_lock_sel = 2'b11; end
         default: begin w_lock_hit = 1'b0; w_lock_sel = 2'b00; end
      endcase
   end

   // select2 may change only once per reset so the SYNC BUFGMUX never sees
   // a second switch request.
   always_ff @(posedge clock) begin
      if (reset) begin
         phase_locked <= 1'b0;
         select2      <= 2'b00;
         select4      <= 4'b0000;
      end else if (!phase_locked && w_lock_hit) begin
         phase_locked <= 1'b1;
         select2      <= w_lock_sel;
         select4      <= pulse_stream;
      end
   end

   // ------------------------------------------------------------------------
   // Trigger chain. short_trg fires once per rising edge of long_trg, so a
   // marker held for many words still yields a single trigger; a new one
   // needs at least one all-zero word in between.
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         long_trg     <= 1'b0;
         r_long_trg_d <= 1'b0;
         short_trg    <= 1'b0;
         trg          <= 1'b0;
         trg_inv      <= 1'b1;
         word         <= WORD_NULL;
      end else begin
         long_trg     <= |revo_stream;
         r_long_trg_d <= long_trg;
         short_trg    <= long_trg & ~r_long_trg_d;
         trg          <= short_trg;
         trg_inv      <= ~short_trg;
         word         <= trg ? WORD_TRG : WORD_NULL;
      end
   end

   // ------------------------------------------------------------------------
   // LED stretch. sticky collects any edge activity; on each counter wrap it
   // is transferred to the LED and cleared. An edge arriving on the wrap
   // cycle itself must not be lost, so the set takes priority over the clear.
   // ------------------------------------------------------------------------
   assign w_any_pulse = |pulse_stream;
   assign w_wrap      = (r_counter == '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_counter <= '0;
         r_sticky  <= 1'b0;
         led_revo  <= 1'b0;
      end else begin
         r_counter <= r_counter + CNT_ONE;
         if (w_wrap) begin
            led_revo <= r_sticky;
            r_sticky <= w_any_pulse;
         end else if (w_any_pulse) begin
            r_sticky <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_revo_phase_select_trigger_encoder.sv
module tb_revo_phase_select_trigger_encoder;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] revo_stream = 4'b0000;
   logic [3:0] pulse_stream;
   logic       phase_locked;
   logic [1:0] select2;
   logic [3:0] select4;
   logic       long_trg, short_trg, trg, trg_inv;
   logic [7:0] word;
   logic       led_revo;

   revo_phase_select_trigger_encoder #(.STRETCH_LOG2(4)) dut (
      .clock(clock), .reset(reset), .revo_stream(revo_stream),
      .pulse_stream(pulse_stream), .phase_locked(phase_locked),
      .select2(select2), .select4(select4), .long_trg(long_trg),
      .short_trg(short_trg), .trg(trg), .trg_inv(trg_inv),
      .word(word), .led_revo(led_revo)
   );

   always #5 clock = ~clock;

   // mask bits: 0 pulse, 1 lock group, 2 trigger group + word, 3 led
   localparam logic [3:0] M_PUL = 4'b0001, M_LCK = 4'b0010, M_TRG = 4'b0100,
                          M_LED = 4'b1000, M_ALL = 4'b1111;

   typedef struct {
      string      nm;
      logic [3:0] m;
      logic [3:0] pul;
      logic       lk;
      logic [1:0] s2;
      logic [3:0] s4;
      logic [3:0] tr;   // {long_trg, short_trg, trg, trg_inv}
      logic [7:0] w;
      logic       led;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   bit   drv_done = 0;

   task automatic chk(input string n, input logic [7:0] a, input logic [7:0] x);
      total++;
      if (a !== x) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", n, a, x);
      end
   endtask

   // Drive one word and queue what the DUT must show after the next edge.
   task automatic step(input logic rst, input logic [3:0] s, input string nm,
                       input logic [3:0] m, input logic [3:0] pul, input logic lk,
                       input logic [1:0] s2, input logic [3:0] s4,
                       input logic [3:0] tr, input logic [7:0] w, input logic led);
      exp_t e;
      @(negedge clock);
      reset = rst;
      revo_stream = s;
      e.nm = nm; e.m = m; e.pul = pul; e.lk = lk; e.s2 = s2; e.s4 = s4;
      e.tr = tr; e.w = w; e.led = led;
      q.push_back(e);
   endtask

   task automatic do_reset();
      step(1'b1, 4'b0000, "rst", 4'b0000, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: one expected record per clock edge, compared 1 time unit later.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.m[0]) chk({e.nm, ".pulse"}, {4'b0, pulse_stream}, {4'b0, e.pul});
            if (e.m[1]) begin
               chk({e.nm, ".locked"},  {7'b0, phase_locked}, {7'b0, e.lk});
               chk({e.nm, ".select2"}, {6'b0, select2},      {6'b0, e.s2});
               chk({e.nm, ".select4"}, {4'b0, select4},      {4'b0, e.s4});
            end
            if (e.m[2]) begin
               chk({e.nm, ".trg_grp"}, {4'b0, long_trg, short_trg, trg, trg_inv}, {4'b0, e.tr});
               chk({e.nm, ".word"},    word, e.w);
            end
            if (e.m[3]) chk({e.nm, ".led"}, {7'b0, led_revo}, {7'b0, e.led});
         end
      end
   end

   initial begin
      logic [3:0] pats [3];
      logic [1:0] sels [3];
      logic [3:0] s;
      logic       led_x;
      pats[0] = 4'b1111; pats[1] = 4'b1110; pats[2] = 4'b1000;
      sels[0] = 2'b00;   sels[1] = 2'b01;   sels[2] = 2'b11;

      // Reset state and idle input
      do_reset();
      step(1, 4'b0000, "rst_state", M_ALL, 0, 0, 0, 0, 4'b0001, 8'h00, 0);
      for (int i = 0; i < 50; i++)
         step(0, 4'b0000, "idle", M_ALL, 0, 0, 0, 0, 4'b0001, 8'h00, 0);

      // 1100 edge locks 90/180 phase, later edges ignored
      do_reset();
      step(0, 4'b1100, "b_edge", M_PUL | M_LCK, 4'b1100, 0, 2'b00, 4'b0000, 0, 0, 0);
      step(0, 4'b1100, "b_lock", M_PUL | M_LCK, 4'b0000, 1, 2'b10, 4'b1100, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         step(0, 4'b1100, "b_hold", M_PUL | M_LCK, 4'b0000, 1, 2'b10, 4'b1100, 0, 0, 0);
      step(0, 4'b0000, "b_low",   M_LCK, 0, 1, 2'b10, 4'b1100, 0, 0, 0);
      step(0, 4'b1111, "b_late",  M_PUL | M_LCK, 4'b1111, 1, 2'b10, 4'b1100, 0, 0, 0);
      step(0, 4'b0000, "b_after", M_LCK, 0, 1, 2'b10, 4'b1100, 0, 0, 0);

      // Remaining lock patterns, each from a fresh reset
      for (int i = 0; i < 3; i++) begin
         do_reset();
         step(0, pats[i], "c_edge", M_PUL | M_LCK, pats[i], 0, 2'b00, 4'b0000, 0, 0, 0);
         step(0, 4'b0000, "c_lock", M_LCK, 0, 1, sels[i], pats[i], 0, 0, 0);
      end

      // Non-table patterns ignored, then 1110 locks
      do_reset();
      step(0, 4'b0110, "c_0110", M_PUL | M_LCK, 4'b0110, 0, 0, 0, 0, 0, 0);
      step(0, 4'b0000, "c_nolk1", M_LCK, 0, 0, 0, 0, 0, 0, 0);
      step(0, 4'b0001, "c_0001", M_PUL | M_LCK, 4'b0001, 0, 0, 0, 0, 0, 0);
      step(0, 4'b0000, "c_nolk2", M_LCK, 0, 0, 0, 0, 0, 0, 0);
      step(0, 4'b1110, "c_1110", M_PUL | M_LCK, 4'b1110, 0, 0, 0, 0, 0, 0);
      step(0, 4'b0000, "c_lk1110", M_LCK, 0, 1, 2'b01, 4'b1110, 0, 0, 0);

      // Trigger latency for a single word 0011
      do_reset();
      step(0, 4'b0000, "d_pre", M_TRG, 0, 0, 0, 0, 4'b0001, 8'h00, 0);
      step(0, 4'b0011, "d_n",   M_TRG | M_PUL | M_LCK, 4'b0011, 0, 0, 0, 4'b1001, 8'h00, 0);
      step(0, 4'b0000, "d_n1",  M_TRG | M_LCK, 0, 0, 0, 0, 4'b0101, 8'h00, 0);
      step(0, 4'b0000, "d_n2",  M_TRG, 0, 0, 0, 0, 4'b0010, 8'h00, 0);
      step(0, 4'b0000, "d_n3",  M_TRG, 0, 0, 0, 0, 4'b0001, 8'hCC, 0);
      step(0, 4'b0000, "d_n4",  M_TRG, 0, 0, 0, 0, 4'b0001, 8'h00, 0);

      // Input held nonzero for 10 words: still one CC word
      step(0, 4'b1111, "d_h1", M_TRG, 0, 0, 0, 0, 4'b1001, 8'h00, 0);
      step(0, 4'b1111, "d_h2", M_TRG, 0, 0, 0, 0, 4'b1101, 8'h00, 0);
      step(0, 4'b1111, "d_h3", M_TRG, 0, 0, 0, 0, 4'b1010, 8'h00, 0);
      step(0, 4'b1111, "d_h4", M_TRG, 0, 0, 0, 0, 4'b1001, 8'hCC, 0);
      for (int i = 0; i < 6; i++)
         step(0, 4'b1111, "d_hx", M_TRG, 0, 0, 0, 0, 4'b1001, 8'h00, 0);
      for (int i = 0; i < 3; i++)
         step(0, 4'b0000, "d_tail", M_TRG, 0, 0, 0, 0, (i == 0) ? 4'b0001 : 4'b0001, 8'h00, 0);

      // LED stretch (counter period 16). Wraps evaluated at edges 1,17,33,49,65,81.
      // Edge at 2 -> led 1 over 17..32. Edge pulse presented exactly at wrap 49
      // -> led stays 0 at 49, goes 1 at 65, back to 0 at 81.
      do_reset();
      for (int k = 1; k <= 84; k++) begin
         s     = (k == 2) ? 4'b1000 : ((k == 48) ? 4'b0100 : 4'b0000);
         led_x = ((k >= 17) && (k <= 32)) || ((k >= 65) && (k <= 80));
         step(0, s, "e_led", M_LED, 0, 0, 0, 0, 0, 0, led_x);
      end

      // Reset mid-trigger while locked
      do_reset();
      step(0, 4'b0000, "f_pre",  M_TRG, 0, 0, 0, 0, 4'b0001, 8'h00, 0);
      step(0, 4'b1000, "f_n",    M_TRG | M_PUL, 4'b1000, 0, 0, 0, 4'b1001, 8'h00, 0);
      step(0, 4'b0000, "f_n1",   M_TRG | M_LCK, 0, 1, 2'b11, 4'b1000, 4'b0101, 8'h00, 0);
      step(0, 4'b0000, "f_n2",   M_TRG | M_LCK, 0, 1, 2'b11, 4'b1000, 4'b0010, 8'h00, 0);
      step(1, 4'b0000, "f_rst",  M_TRG | M_LCK, 0, 0, 2'b00, 4'b0000, 4'b0001, 8'h00, 0);
      step(0, 4'b0000, "f_rel",  M_TRG | M_LCK, 0, 0, 2'b00, 4'b0000, 4'b0001, 8'h00, 0);
      step(0, 4'b1000, "f_edge", M_PUL | M_LCK, 4'b1000, 0, 2'b00, 4'b0000, 0, 0, 0);
      step(0, 4'b0000, "f_lock", M_LCK, 0, 1, 2'b11, 4'b1000, 0, 0, 0);

      drv_done = 1;
   end

   initial begin
      int waited;
      wait (drv_done);
      waited = 0;
      while (q.size() > 0 && waited < 20) begin
         @(negedge clock);
         waited++;
      end
      @(negedge clock);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d exp=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule

// File: doc/revo_phase_select_trigger_encoder.md
Name: revo_phase_select_trigger_encoder

Overview:
Single-clock back end of the revolution-marker (revo) path. It takes 4-sample words of deserialized revo input, detects rising edges and locks a one-time phase selection (select2/select4) for the downstream clock-phase BUFGMUX tree. It then produces a one-cycle trigger with its complement for the ODDR clock-encoding gate, an 8-bit calibration word for the output serializer, and a stretched activity indicator for the revo LED.

Parameters:
STRETCH_LOG2, 19, width of the free-running LED update counter; the indicator updates once every 2^STRETCH_LOG2 clocks.
WORD_TRG, 8'b11001100, serializer word emitted for one cycle per trigger.
WORD_NULL, 8'b00000000, serializer word emitted otherwise.

Ports:
clock  input  1  word clock; all logic is on its rising edge.
reset  input  1  synchronous, active-high.
revo_stream  input  4  deserialized revo samples; already synchronous to clock.
pulse_stream  output  4  registered rising-edge pulses per sample bit.
phase_locked  output  1  high once a phase has been captured.
select2  output  2  phase select for the BUFGMUX tree (0/90/180/270 degrees).
select4  output  4  edge pattern captured at lock.
long_trg  output  1  registered OR of revo_stream.
short_trg  output  1  one-cycle pulse on each rising edge of long_trg.
trg  output  1  registered copy of short_trg.
trg_inv  output  1  complement of trg; drives the ODDR CE.
word  output  8  serializer word.
led_revo  output  1  stretched "revo seen" indicator.

Behaviour:
- Reset (synchronous, priority over everything). Cleared to 0: stream_d, pulse_stream, select2, select4, phase_locked, long_trg, long_trg_d, short_trg, trg, sticky, counter, led_revo. trg_inv resets to 1. word resets to WORD_NULL.
- Edge detect, every clock:
  - stream_d <= revo_stream.
  - pulse_stream <= revo_stream & ~stream_d.
  - Latency is 1 clock from the input word.
- Phase lock. While phase_locked = 0, each clock compares pulse_stream against the table below; on a match, select4 <= pulse_stream and phase_locked <= 1 in the same cycle.
  - 1111 -> select2 = 00
  - 1110 -> select2 = 01
  - 1100 -> select2 = 10
  - 1000 -> select2 = 11
  - Any other pattern, including 0000, 0001 and non-contiguous patterns, is ignored.
- Once locked, select2, select4 and phase_locked hold until reset; later edges have no effect. select2 therefore changes at most once per reset, as required for a glitch-free SYNC BUFGMUX.
- Trigger chain:
  - long_trg <= |revo_stream.
  - long_trg_d <= long_trg.
  - short_trg <= long_trg & ~long_trg_d.
  - trg <= short_trg; trg_inv <= ~short_trg.
  - word <= trg ? WORD_TRG : WORD_NULL.
  - Latency from input word at edge n: long_trg after n, short_trg after n+1, trg after n+2, word after n+3.
  - Each pulse lasts exactly 1 clock, regardless of how long revo_stream stays nonzero. A new trigger requires revo_stream to return to 0000 for at least one clock.
- Indicator:
  - sticky is set whenever pulse_stream != 0.
  - counter (STRETCH_LOG2 bits) increments every clock and wraps.
  - When counter == 0: led_revo <= sticky (pre-update value) and sticky is cleared.
  - If a set and a clear coincide, the set wins and sticky stays 1.
- Reset asserted mid-operation drops the lock, cancels any in-flight trigger (word returns to WORD_NULL next clock) and re-arms phase capture.

Test Plan:
- Reset, then revo_stream = 0000 for 50 clocks -> phase_locked = 0, select2 = 00, word = 00, trg_inv = 1, led_revo = 0.
- revo_stream 0000 -> 1100 held for 5 clocks -> pulse_stream = 1100 for 1 clock; next clock select2 = 10, select4 = 1100, phase_locked = 1; a later 1111 edge leaves select2 = 10.
- Separately from reset, apply each lock pattern (1111, 1110, 1000) -> select2 = 00, 01, 11 respectively. Apply 0110 then 0001 -> no lock. Then 1110 -> lock with select2 = 01.
- Single input word 0011 at edge n -> short_trg high only after edge n+1, trg/trg_inv = 1/0 only after n+2, word = 8'hCC only after n+3, then 00. Input held nonzero for 10 clocks -> still exactly one CC word.
- STRETCH_LOG2 = 4, one edge at clock 3 -> led_revo = 1 at counter wrap 16, back to 0 at wrap 32. Edge landing exactly on a wrap -> led_revo = 1 at the following wrap.
- Assert reset while trg = 1 and locked -> next clock trg = 0, trg_inv = 1, word = 00, phase_locked = 0. After release, a new 1000 edge locks select2 = 11.
